// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the encoder (loader) side and the decoder side.
// Holds the opcode and funct constants, the op_sel enumeration, the request
// field payload struct and small word-packing helpers.
package mips_isa_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned TARGET_W = 26;

    // Primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Operation select; codes 10..15 are illegal
    typedef enum logic [3:0] {
        OPS_ADD  = 4'd0,
        OPS_SUB  = 4'd1,
        OPS_AND  = 4'd2,
        OPS_OR   = 4'd3,
        OPS_SLT  = 4'd4,
        OPS_LW   = 4'd5,
        OPS_SW   = 4'd6,
        OPS_BEQ  = 4'd7,
        OPS_ADDI = 4'd8,
        OPS_J    = 4'd9
    } op_sel_e;

    // Symbolic instruction fields carried with a request
    typedef struct packed {
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [IMM_W-1:0]    imm;
        logic [TARGET_W-1:0] target;
    } instr_fields_t;

    function automatic logic [WORD_W-1:0] enc_r(instr_fields_t f, logic [5:0] funct);
        return {OPC_RTYPE, f.rs, f.rt, f.rd, 5'h00, funct};
    endfunction

    function automatic logic [WORD_W-1:0] enc_i(instr_fields_t f, logic [5:0] opc);
        return {opc, f.rs, f.rt, f.imm};
    endfunction

    function automatic logic [WORD_W-1:0] enc_j(instr_fields_t f);
        return {OPC_J, f.target};
    endfunction

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational op_sel/fields -> 32-bit MIPS word mapping with a legal flag.
// Ports: op_sel_i (operation select), fields_i (register/imm/target fields),
//        enc_word_c (encoded word, 0 when illegal), legal_c (op_sel is legal).
module instr_word_encoder
    import mips_isa_pkg::*;
#(
    parameter int unsigned OPSEL_W = 4
) (
    input  logic [OPSEL_W-1:0] op_sel_i,
    input  instr_fields_t      fields_i,
    output logic [WORD_W-1:0]  enc_word_c,
    output logic               legal_c
);

    // Only the fields belonging to the instruction format are packed
    always_comb begin
        enc_word_c = '0;
        legal_c    = 1'b1;
        case (op_sel_i)
            OPSEL_W'(OPS_ADD):  enc_word_c = enc_r(fields_i, FUNCT_ADD);
            OPSEL_W'(OPS_SUB):  enc_word_c = enc_r(fields_i, FUNCT_SUB);
            OPSEL_W'(OPS_AND):  enc_word_c = enc_r(fields_i, FUNCT_AND);
            OPSEL_W'(OPS_OR):   enc_word_c = enc_r(fields_i, FUNCT_OR);
            OPSEL_W'(OPS_SLT):  enc_word_c = enc_r(fields_i, FUNCT_SLT);
            OPSEL_W'(OPS_LW):   enc_word_c = enc_i(fields_i, OPC_LW);
            OPSEL_W'(OPS_SW):   enc_word_c = enc_i(fields_i, OPC_SW);
            OPSEL_W'(OPS_BEQ):  enc_word_c = enc_i(fields_i, OPC_BEQ);
            OPSEL_W'(OPS_ADDI): enc_word_c = enc_i(fields_i, OPC_ADDI);
            OPSEL_W'(OPS_J):    enc_word_c = enc_j(fields_i);
            default:            legal_c    = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction requests into MIPS words and writes them
// sequentially into instruction memory from a programmable base address.
// Ports: clk/reset (async active-high); start/base_addr open a session;
//   in_valid/in_ready/in_last + op_sel/rs/rt/rd/imm/target form the request
//   stream; imem_we/imem_addr/imem_wdata drive the memory write port;
//   word_count/busy/done/err_illegal report session status.
// Optional macro ENC_READBACK_EN adds imem_rdata/mismatch and a VERIFY state
//   that reads back each written word.
module instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned OPSEL_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [OPSEL_W-1:0]  op_sel,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rt,
    input  logic [REG_W-1:0]    rd,
    input  logic [IMM_W-1:0]    imm,
    input  logic [TARGET_W-1:0] target,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [WORD_W-1:0]   imem_wdata,
    output logic [ADDR_W-1:0]   word_count,
    output logic                busy,
    output logic                done,
`ifdef ENC_READBACK_EN
    input  logic [WORD_W-1:0]   imem_rdata,
    output logic                mismatch,
`endif
    output logic                err_illegal
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
`ifdef ENC_READBACK_EN
        ST_VERIFY,
`endif
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                last_q, last_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef ENC_READBACK_EN
    logic                mismatch_q, mismatch_d;
`endif

    instr_fields_t       fields;
    logic [WORD_W-1:0]   enc_word;
    logic                enc_legal;
    logic                session_end;

    assign fields = '{rs: rs, rt: rt, rd: rd, imm: imm, target: target};

    instr_word_encoder #(.OPSEL_W(OPSEL_W)) u_enc (
        .op_sel_i   (op_sel),
        .fields_i   (fields),
        .enc_word_c (enc_word),
        .legal_c    (enc_legal)
    );

    // Session ends after the flagged last word or when the word cap is hit
    assign session_end = last_q || ((count_q + ADDR_W'(1)) == ADDR_W'(MAX_WORDS));

    // Next-state and status logic; status registers follow the next state
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        err_d   = err_q;
`ifdef ENC_READBACK_EN
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    addr_d  = base_addr & ~ADDR_W'(3);
                    count_d = '0;
                    err_d   = 1'b0;
`ifdef ENC_READBACK_EN
                    mismatch_d = 1'b0;
`endif
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (in_valid && ready_q) begin
                    if (enc_legal) begin
                        wdata_d = enc_word;
                        last_d  = in_last;
                        state_d = ST_WRITE;
                    end else begin
                        // Illegal requests are consumed and dropped
                        err_d = 1'b1;
                        if (in_last) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
`ifdef ENC_READBACK_EN
            ST_WRITE: state_d = ST_VERIFY;
            ST_VERIFY: begin
                // Address is still held here, so rdata is the word just written
                if (imem_rdata != wdata_q) begin
                    mismatch_d = 1'b1;
                end
                addr_d  = addr_q + ADDR_W'(4);
                count_d = count_q + ADDR_W'(1);
                state_d = session_end ? ST_DONE : ST_ACCEPT;
            end
`else
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(4);
                count_d = count_q + ADDR_W'(1);
                state_d = session_end ? ST_DONE : ST_ACCEPT;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_ACCEPT);
        we_d    = (state_d == ST_WRITE);
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ENC_READBACK_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ENC_READBACK_EN
            mismatch_q <= mismatch_d;
`endif
        end
    end

    assign in_ready    = ready_q;
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign word_count  = count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_illegal = err_q;
`ifdef ENC_READBACK_EN
    assign mismatch    = mismatch_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (word cap set to 4).
module tb_instr_encoder_loader;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned MAXW   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [3:0]  op_sel = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata, word_count;
    logic        busy, done, err_illegal;
`ifdef ENC_READBACK_EN
    logic [31:0] imem_rdata = '0;
    logic        mismatch;
    logic        corrupt = 1'b0;
`endif

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW), .OPSEL_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .busy(busy), .done(done),
`ifdef ENC_READBACK_EN
        .imem_rdata(imem_rdata), .mismatch(mismatch),
`endif
        .err_illegal(err_illegal)
    );

`ifdef ENC_READBACK_EN
    // One-word memory model: returns the last written word, optionally corrupted
    always @(posedge clk) if (imem_we) imem_rdata <= imem_wdata ^ {31'h0, corrupt};
`endif

    // Write monitor: one entry per imem_we cycle, {addr, data}
    logic [63:0] wq[$];
    always @(negedge clk) if (imem_we) wq.push_back({imem_addr, imem_wdata});

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic start_session(input logic [31:0] base);
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        wq.delete();
    endtask

    // Present one request; acc=1 if it handshook within the budget. Returns #1 after the edge.
    task automatic send(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg,
                        input logic last, output bit acc);
        @(negedge clk);
        op_sel = op; rs = s; rt = t; rd = d; imm = im; target = tg; in_last = last;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_reached", {31'h0, seen}, 32'h1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] base;
        logic [31:0] exp_addr;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[11];

    initial begin
        bit acc;
        int n;
        logic [63:0] e;

        // op, rs, rt, rd, imm, target, base, expected addr, expected word
        vecs[0]  = '{4'd0, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h100, 32'h100, 32'h00221820};
        vecs[1]  = '{4'd1, 5'd4,  5'd5,  5'd6,  16'h0000, 26'h0,       32'h104, 32'h104, 32'h00853022};
        vecs[2]  = '{4'd2, 5'd7,  5'd8,  5'd9,  16'h0000, 26'h0,       32'h10B, 32'h108, 32'h00E84824};
        vecs[3]  = '{4'd3, 5'd31, 5'd0,  5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h110, 32'h110, 32'h03E0F825};
        vecs[4]  = '{4'd4, 5'd2,  5'd3,  5'd1,  16'h0000, 26'h0,       32'h120, 32'h120, 32'h0043082A};
        vecs[5]  = '{4'd5, 5'd0,  5'd8,  5'd31, 16'h0004, 26'h3FFFFFF, 32'h130, 32'h130, 32'h8C080004};
        vecs[6]  = '{4'd6, 5'd29, 5'd31, 5'd0,  16'h0010, 26'h0,       32'h140, 32'h140, 32'hAFBF0010};
        vecs[7]  = '{4'd7, 5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       32'h150, 32'h150, 32'h1022FFFF};
        vecs[8]  = '{4'd8, 5'd1,  5'd1,  5'd31, 16'h8000, 26'h0,       32'h162, 32'h160, 32'h20218000};
        vecs[9]  = '{4'd9, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h10,      32'h170, 32'h170, 32'h08000010};
        vecs[10] = '{4'd9, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h180, 32'h180, 32'h0BFFFFFF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_we", {31'h0, imem_we}, 32'h0);
        chk("idle_done", {31'h0, done}, 32'h0);
        chk("idle_err", {31'h0, err_illegal}, 32'h0);
        chk("idle_addr", imem_addr, 32'h0);
        chk("idle_wdata", imem_wdata, 32'h0);
        chk("idle_count", word_count, 32'h0);

        // Single-word sessions, one per encoding vector
        foreach (vecs[i]) begin
            start_session(vecs[i].base);
            chk("accept_ready", {31'h0, in_ready}, 32'h1);
            chk("accept_busy", {31'h0, busy}, 32'h1);
            send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt, 1'b1, acc);
            chk("vec_accepted", {31'h0, acc}, 32'h1);
            chk("vec_we_latency", {31'h0, imem_we}, 32'h1);
            chk("vec_write_ready", {31'h0, in_ready}, 32'h0);
            wait_done();
            chk("vec_nwrites", 32'(wq.size()), 32'd1);
            if (wq.size() > 0) begin
                e = wq[0];
                chk("vec_addr", e[63:32], vecs[i].exp_addr);
                chk("vec_word", e[31:0], vecs[i].exp_word);
            end
            chk("vec_count", word_count, 32'd1);
            chk("vec_busy", {31'h0, busy}, 32'h0);
            chk("vec_ready_done", {31'h0, in_ready}, 32'h0);
            chk("vec_err", {31'h0, err_illegal}, 32'h0);
`ifdef ENC_READBACK_EN
            chk("vec_mismatch", {31'h0, mismatch}, 32'h0);
`endif
        end

        // Two-word stream: LW then BEQ(last)
        start_session(32'h200);
        send(4'd5, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0, acc);
        send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b1, acc);
        wait_done();
        chk("two_nwrites", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("two_w0", wq[0][31:0], 32'h8C080004);
            chk("two_a0", wq[0][63:32], 32'h200);
            chk("two_w1", wq[1][31:0], 32'h1022FFFF);
            chk("two_a1", wq[1][63:32], 32'h204);
        end
        chk("two_count", word_count, 32'd2);

        // Illegal op mid-stream is dropped; next write is consecutive
        start_session(32'h300);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, acc);
        send(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, acc);
        chk("ill_accepted", {31'h0, acc}, 32'h1);
        chk("ill_no_we", {31'h0, imem_we}, 32'h0);
        chk("ill_err_set", {31'h0, err_illegal}, 32'h1);
        chk("ill_still_ready", {31'h0, in_ready}, 32'h1);
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1, acc);
        wait_done();
        chk("ill_nwrites", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("ill_a1", wq[1][63:32], 32'h304);
            chk("ill_w1", wq[1][31:0], 32'h00853022);
        end
        chk("ill_count", word_count, 32'd2);
        chk("ill_err_sticky", {31'h0, err_illegal}, 32'h1);

        // Illegal op carrying in_last ends the session with no write
        start_session(32'h380);
        chk("err_cleared", {31'h0, err_illegal}, 32'h0);
        send(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, acc);
        wait_done();
        chk("illast_nwrites", 32'(wq.size()), 32'd0);
        chk("illast_err", {31'h0, err_illegal}, 32'h1);
        chk("illast_count", word_count, 32'd0);

        // Word cap: 6 requests without in_last, only 4 accepted
        start_session(32'h400);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            send(4'd0, 5'(i), 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, acc);
            if (acc) n++;
        end
        chk("cap_accepted", 32'(n), 32'd4);
        chk("cap_nwrites", 32'(wq.size()), 32'd4);
        if (wq.size() == 4) chk("cap_last_addr", wq[3][63:32], 32'h40C);
        chk("cap_done", {31'h0, done}, 32'h1);
        chk("cap_ready", {31'h0, in_ready}, 32'h0);
        chk("cap_count", word_count, 32'd4);

        // Address wraps modulo 2^32
        start_session(32'hFFFF_FFFC);
        send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b0, acc);
        send(4'd8, 5'd1, 5'd1, 5'd0, 16'h8000, 26'h0, 1'b1, acc);
        wait_done();
        chk("wrap_nwrites", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("wrap_a0", wq[0][63:32], 32'hFFFF_FFFC);
            chk("wrap_a1", wq[1][63:32], 32'h0000_0000);
            chk("wrap_w1", wq[1][31:0], 32'h20218000);
        end

        // Reset asserted during WRITE clears everything at once
        start_session(32'h600);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, acc);
        chk("rw_in_write", {31'h0, imem_we}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rw_we", {31'h0, imem_we}, 32'h0);
        chk("rw_busy", {31'h0, busy}, 32'h0);
        chk("rw_done", {31'h0, done}, 32'h0);
        chk("rw_ready", {31'h0, in_ready}, 32'h0);
        chk("rw_addr", imem_addr, 32'h0);
        chk("rw_wdata", imem_wdata, 32'h0);
        chk("rw_count", word_count, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        start_session(32'h700);
        chk("rw_new_count", word_count, 32'h0);
        chk("rw_new_base", imem_addr, 32'h700);
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1, acc);
        wait_done();
        chk("rw_nwrites", 32'(wq.size()), 32'd1);
        if (wq.size() == 1) chk("rw_a0", wq[0][63:32], 32'h700);

`ifdef ENC_READBACK_EN
        // Corrupted readback sets mismatch; next start clears it
        start_session(32'h800);
        corrupt = 1'b1;
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, acc);
        wait_done();
        corrupt = 1'b0;
        chk("rb_mismatch", {31'h0, mismatch}, 32'h1);
        start_session(32'h900);
        chk("rb_cleared", {31'h0, mismatch}, 32'h0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, acc);
        wait_done();
        chk("rb_clean", {31'h0, mismatch}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
